// File: rtl/morse_pkg.sv
// Shared Morse timing, state encoding and code-table helpers
// used by the encoder and its character table.
package morse_pkg;

  localparam int LEN_W = 3;
  localparam int PAT_W = 6;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MARK     = 3'd1;
  localparam logic [2:0] S_ELEM_GAP = 3'd2;
  localparam logic [2:0] S_CHAR_GAP = 3'd3;
  localparam logic [2:0] S_WORD_GAP = 3'd4;

  typedef struct packed {
    logic             valid;
    logic             is_space;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
  } morse_code_t;

  // pattern bit0 is the first element, 1 = dash
  function automatic morse_code_t sym(
    input logic [LEN_W-1:0] len,
    input logic [PAT_W-1:0] pattern
  );
    morse_code_t c;
    c.valid    = 1'b1;
    c.is_space = 1'b0;
    c.len      = len;
    c.pattern  = pattern;
    return c;
  endfunction

  function automatic logic [7:0] to_upper(
    input logic [7:0] c
  );
    if (c >= 8'h61 && c <= 8'h7A)
      return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/morse_code_rom.sv
// Combinational ASCII to Morse lookup, case-insensitive.
// Shared by the encoder and the decoder's reverse lookup.
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [7:0]       ascii,
  output logic             valid,
  output logic             is_space,
  output logic [LEN_W-1:0] len,
  output logic [PAT_W-1:0] pattern
);

  logic [7:0]  up;
  morse_code_t code;

  assign up = to_upper(ascii);

  always_comb begin
    code = '0;
    case (up)
      8'h41: code = sym(3'd2, 6'b000010);
      8'h42: code = sym(3'd4, 6'b000001);
      8'h43: code = sym(3'd4, 6'b000101);
      8'h44: code = sym(3'd3, 6'b000001);
      8'h45: code = sym(3'd1, 6'b000000);
      8'h46: code = sym(3'd4, 6'b000100);
      8'h47: code = sym(3'd3, 6'b000011);
      8'h48: code = sym(3'd4, 6'b000000);
      8'h49: code = sym(3'd2, 6'b000000);
      8'h4A: code = sym(3'd4, 6'b001110);
      8'h4B: code = sym(3'd3, 6'b000101);
      8'h4C: code = sym(3'd4, 6'b000010);
      8'h4D: code = sym(3'd2, 6'b000011);
      8'h4E: code = sym(3'd2, 6'b000001);
      8'h4F: code = sym(3'd3, 6'b000111);
      8'h50: code = sym(3'd4, 6'b000110);
      8'h51: code = sym(3'd4, 6'b001011);
      8'h52: code = sym(3'd3, 6'b000010);
      8'h53: code = sym(3'd3, 6'b000000);
      8'h54: code = sym(3'd1, 6'b000001);
      8'h55: code = sym(3'd3, 6'b000100);
      8'h56: code = sym(3'd4, 6'b001000);
      8'h57: code = sym(3'd3, 6'b000110);
      8'h58: code = sym(3'd4, 6'b001001);
      8'h59: code = sym(3'd4, 6'b001101);
      8'h5A: code = sym(3'd4, 6'b000011);
      8'h30: code = sym(3'd5, 6'b011111);
      8'h31: code = sym(3'd5, 6'b011110);
      8'h32: code = sym(3'd5, 6'b011100);
      8'h33: code = sym(3'd5, 6'b011000);
      8'h34: code = sym(3'd5, 6'b010000);
      8'h35: code = sym(3'd5, 6'b000000);
      8'h36: code = sym(3'd5, 6'b000001);
      8'h37: code = sym(3'd5, 6'b000011);
      8'h38: code = sym(3'd5, 6'b000111);
      8'h39: code = sym(3'd5, 6'b001111);
      8'h2E: code = sym(3'd6, 6'b101010);
      8'h2D: code = sym(3'd6, 6'b100001);
      8'h3F: code = sym(3'd6, 6'b001100);
      8'h20: begin
        code.valid    = 1'b1;
        code.is_space = 1'b1;
      end
      default: code = '0;
    endcase
  end

  assign valid    = code.valid;
  assign is_space = code.is_space;
  assign len      = code.len;
  assign pattern  = code.pattern;

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: valid/ready character input, table lookup,
// unit-timed keying output.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_char,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       unknown_char
);

  localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(UNIT_CYCLES - 1);

  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] presc;
  logic [2:0]       unit_cnt;
  logic [2:0]       idx, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             unk_d;

  logic             rom_valid;
  logic             rom_space;
  logic [LEN_W-1:0] rom_len;
  logic [PAT_W-1:0] rom_pat;

  logic       accept;
  logic       tick;
  logic       phase_done;
  logic       last_elem;
  logic       enter;
  logic [2:0] phase_units;

  morse_code_rom u_rom (
    .ascii    (ascii_char),
    .valid    (rom_valid),
    .is_space (rom_space),
    .len      (rom_len),
    .pattern  (rom_pat)
  );

  assign char_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign accept     = char_valid && char_ready;
  assign tick       = (presc == LAST_TICK);
  assign last_elem  = (idx == len_q - 3'd1);

  always_comb begin
    phase_units = DOT_UNITS;
    case (state)
      S_MARK:
        phase_units = pat_q[idx] ? DASH_UNITS : DOT_UNITS;
      S_ELEM_GAP: phase_units = ELEM_GAP_UNITS;
      S_CHAR_GAP: phase_units = CHAR_GAP_UNITS;
      S_WORD_GAP: phase_units = WORD_GAP_UNITS;
      default:    phase_units = DOT_UNITS;
    endcase
  end

  assign phase_done = tick && (unit_cnt == phase_units - 3'd1);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    len_d   = len_q;
    pat_d   = pat_q;
    unk_d   = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        len_d = rom_len;
        pat_d = rom_pat;
        idx_d = 3'd0;
        if (!rom_valid)     unk_d   = 1'b1;
        else if (rom_space) state_d = S_WORD_GAP;
        else                state_d = S_MARK;
      end
      S_MARK: if (phase_done)
        state_d = last_elem ? S_CHAR_GAP : S_ELEM_GAP;
      S_ELEM_GAP: if (phase_done) begin
        state_d = S_MARK;
        idx_d   = idx + 3'd1;
      end
      S_CHAR_GAP, S_WORD_GAP: if (phase_done)
        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // every phase entry (and idle) restarts the unit timing from zero
  assign enter = (state_d != state) || (state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      presc        <= '0;
      unit_cnt     <= '0;
      idx          <= '0;
      len_q        <= '0;
      pat_q        <= '0;
      key_out      <= 1'b0;
      unknown_char <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      len_q        <= len_d;
      pat_q        <= pat_d;
      key_out      <= (state_d == S_MARK);
      unknown_char <= unk_d;
      if (enter || tick) presc <= '0;
      else               presc <= presc + 1'b1;
      if (enter)     unit_cnt <= '0;
      else if (tick) unit_cnt <= unit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4:
// keying run-lengths, ready timing, unknown symbols, reset abort.
module tb_morse_encoder;

  logic       clk;
  logic       reset;
  logic [7:0] ascii_char;
  logic       char_valid;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       unknown_char;

  int n_chk;
  int n_pass;

  int   run_len [32];
  logic run_val [32];
  int   nruns;
  int   ready_at;
  int   saw_unk;
  int   exp_runs [$];

  morse_encoder #(.UNIT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ascii_char   (ascii_char),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .key_out      (key_out),
    .busy         (busy),
    .unknown_char (unknown_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!char_ready && k < 500) begin
      step();
      k++;
    end
    if (!char_ready) check("wait_ready", 0, 1);
  endtask

  task automatic add_sample(input logic v);
    if (nruns == 0 || run_val[nruns-1] != v) begin
      if (nruns < 32) begin
        run_val[nruns] = v;
        run_len[nruns] = 1;
        nruns++;
      end
    end else begin
      run_len[nruns-1]++;
    end
  endtask

  // sample index 1 is the cycle right after the accepting edge
  task automatic capture();
    nruns    = 0;
    ready_at = 0;
    saw_unk  = 0;
    for (int k = 1; k <= 400; k++) begin
      if (char_ready) begin
        ready_at = k;
        break;
      end
      if (unknown_char) saw_unk = 1;
      add_sample(key_out);
      step();
    end
    if (ready_at == 0) check("capture_timeout", 0, 1);
  endtask

  task automatic send_capture(input logic [7:0] ch);
    wait_ready();
    ascii_char = ch;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
    capture();
  endtask

  task automatic check_runs(input string tag);
    check({tag, "_nruns"}, nruns, exp_runs.size());
    check({tag, "_first_on"}, int'(run_val[0]), 1);
    for (int i = 0; i < exp_runs.size() && i < nruns; i++)
      check($sformatf("%s_run%0d", tag, i),
            run_len[i], exp_runs[i]);
  endtask

  initial begin
    int rdy_cnt;
    int rdy_t [3];
    int rise_t;
    int hi_cnt;
    int bz_cnt;

    n_chk      = 0;
    n_pass     = 0;
    reset      = 1'b1;
    ascii_char = 8'h00;
    char_valid = 1'b0;

    step();
    step();
    check("rst_ready", int'(char_ready), 1);
    check("rst_key", int'(key_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_unk", int'(unknown_char), 0);
    reset = 1'b0;
    step();

    // 'E': dot then 3-unit character gap
    send_capture("E");
    exp_runs = '{4, 12};
    check_runs("E");
    check("E_ready_at", ready_at, 17);
    check("E_unk", saw_unk, 0);

    // lowercase 'a' sends A
    send_capture("a");
    exp_runs = '{4, 4, 12, 12};
    check_runs("a");
    check("a_ready_at", ready_at, 33);
    check("a_unk", saw_unk, 0);

    send_capture("0");
    exp_runs = '{12, 4, 12, 4, 12, 4, 12, 4, 12, 12};
    check_runs("zero");
    check("zero_ready_at", ready_at, 89);

    // unknown '#', then 'T' accepted on the very next edge
    wait_ready();
    ascii_char = "#";
    char_valid = 1'b1;
    step();
    check("hash_unk", int'(unknown_char), 1);
    check("hash_ready", int'(char_ready), 1);
    check("hash_key", int'(key_out), 0);
    ascii_char = "T";
    step();
    char_valid = 1'b0;
    check("T_unk_clear", int'(unknown_char), 0);
    capture();
    exp_runs = '{12, 12};
    check_runs("T");
    check("T_ready_at", ready_at, 25);
    check("T_unk", saw_unk, 0);

    // "E E" with char_valid held high throughout
    wait_ready();
    ascii_char = "E";
    char_valid = 1'b1;
    step();
    ascii_char = " ";
    nruns   = 0;
    rdy_cnt = 0;
    rise_t  = 0;
    rdy_t   = '{0, 0, 0};
    for (int k = 1; k <= 400; k++) begin
      if (char_ready) begin
        rdy_t[rdy_cnt] = k;
        rdy_cnt++;
        if (rdy_cnt == 3) break;
      end
      if (rdy_cnt == 2 && key_out && rise_t == 0)
        rise_t = k;
      add_sample(key_out);
      step();
      if (char_ready == 1'b0 && rdy_cnt == 1)
        ascii_char = "E";
      if (char_ready == 1'b0 && rdy_cnt == 2)
        char_valid = 1'b0;
    end
    char_valid = 1'b0;
    check("EE_ready_cnt", rdy_cnt, 3);
    exp_runs = '{4, 30, 4, 12};
    check_runs("EE");
    check("EE_ready1", rdy_t[0], 17);
    check("EE_ready2", rdy_t[1], 34);
    check("EE_ready3", rdy_t[2], 51);
    check("EE_rise2", rise_t, 35);

    // reset during the dash of 'A'
    wait_ready();
    ascii_char = "A";
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
    for (int k = 0; k < 11; k++) step();
    check("A_mid_key", int'(key_out), 1);
    check("A_mid_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_key", int'(key_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(char_ready), 1);
    step();
    step();
    reset = 1'b0;
    hi_cnt = 0;
    bz_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (key_out) hi_cnt++;
      if (busy) bz_cnt++;
    end
    check("post_rst_key", hi_cnt, 0);
    check("post_rst_busy", bz_cnt, 0);

    send_capture("E");
    exp_runs = '{4, 12};
    check_runs("E2");
    check("E2_ready_at", ready_at, 17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
